// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Purpose  : Shared types and default constants for the register write
//            arbiter slice (FSM state encoding, default parameter values).
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

  // Two-state arbiter FSM with an explicit one-bit encoding
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_t;

  localparam int c_DEF_WIDTH    = 32;
  localparam int c_DEF_NREQ     = 4;
  localparam int c_DEF_MAX_HOLD = 4;
  localparam int c_COUNT_WIDTH  = 16;

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_if
// Purpose  : Bundle of requester-side and register-side signals of the
//            write arbiter. The master modport is the requester/register
//            side; the slave modport is the arbiter itself.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH,
  parameter int NREQ  = c_DEF_NREQ
);

  localparam int IDXW = $clog2(NREQ);

  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          hold;
  logic [NREQ*WIDTH-1:0]    wdata;
  logic [NREQ-1:0]          ack;
  logic                     reg_write_enable;
  logic [WIDTH-1:0]         reg_data_write;
  logic [IDXW-1:0]          grant_id;
  logic                     busy;
  logic [c_COUNT_WIDTH-1:0] write_count;

  modport master (
    output req, hold, wdata,
    input  ack, reg_write_enable, reg_data_write, grant_id, busy, write_count
  );

  modport slave (
    input  req, hold, wdata,
    output ack, reg_write_enable, reg_data_write, grant_id, busy, write_count
  );

endinterface : reg_write_arbiter_if
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating-priority search. Scans requesters
//            starting one past last_grant (wrapping at NREQ) and reports
//            the first asserted request. last_grant itself is scanned last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = c_DEF_NREQ,
  parameter int IDXW = $clog2(NREQ)
) (
  input  wire logic [NREQ-1:0] req,
  input  wire logic [IDXW-1:0] last_grant,
  output logic                 valid,
  output logic [IDXW-1:0]      index
);

  int              w_cand;
  logic [IDXW-1:0] w_candIdx;

  // First asserted request in rotating order after last_grant
  always_comb begin
    valid     = 1'b0;
    index     = '0;
    w_cand    = 0;
    w_candIdx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand    = (int'(last_grant) + i) % NREQ;
      w_candIdx = w_cand[IDXW-1:0];
      if (!valid && req[w_candIdx]) begin
        valid = 1'b1;
        index = w_candIdx;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Arbitrates NREQ requesters onto one shared falling-edge
//            register. Round-robin with a bounded hold exception; every
//            issued write produces a one-cycle one-hot ack. All outputs
//            are registered.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH    = c_DEF_WIDTH,
  parameter int NREQ     = c_DEF_NREQ,
  parameter int MAX_HOLD = c_DEF_MAX_HOLD
) (
  input  wire logic          clk,
  input  wire logic          reset,
  reg_write_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(NREQ);
  // Wide enough to hold MAX_HOLD-1 without overflow
  localparam int HCW  = $clog2(MAX_HOLD) + 1;

  arbState_t                r_state;
  arbState_t                w_nextState;

  logic [IDXW-1:0]          r_lastGrant;
  logic [HCW-1:0]           r_holdCnt;
  logic [NREQ-1:0]          r_ack;
  logic                     r_writeEn;
  logic [WIDTH-1:0]         r_data;
  logic [IDXW-1:0]          r_grantId;
  logic [c_COUNT_WIDTH-1:0] r_count;

  logic                     w_pickValid;
  logic [IDXW-1:0]          w_pickIdx;
  logic                     w_holdWin;
  logic                     w_winValid;
  logic [IDXW-1:0]          w_winIdx;
  logic [HCW-1:0]           w_holdCntNext;
  logic [NREQ-1:0]          w_ackNext;
  logic [WIDTH-1:0]         w_dataNext;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req        (bus.req),
    .last_grant (r_lastGrant),
    .valid      (w_pickValid),
    .index      (w_pickIdx)
  );

  // Winner selection (hold exception over round-robin) and next FSM state
  always_comb begin
    w_nextState   = r_state;
    w_holdWin     = 1'b0;
    w_winValid    = 1'b0;
    w_winIdx      = '0;
    w_holdCntNext = '0;
    w_ackNext     = '0;
    w_dataNext    = '0;

    // Only the previous winner may extend its grant; hold without req is ignored
    w_holdWin  = bus.req[r_lastGrant] && bus.hold[r_lastGrant] &&
                 (int'(r_holdCnt) < (MAX_HOLD - 1));
    w_winValid = w_holdWin || w_pickValid;
    w_winIdx   = w_holdWin ? r_lastGrant : w_pickIdx;

    if (w_holdWin) begin
      w_holdCntNext = r_holdCnt + 1'b1;
    end

    if (w_winValid) begin
      w_ackNext[w_winIdx] = 1'b1;
    end
    w_dataNext = bus.wdata[w_winIdx*WIDTH +: WIDTH];

    case (r_state)
      IDLE:    if (bus.req != '0) w_nextState = GRANT;
      GRANT:   if (bus.req == '0) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Registered outputs, rotation pointer, hold counter and write counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ack       <= '0;
      r_writeEn   <= 1'b0;
      r_data      <= '0;
      r_grantId   <= '0;
      r_count     <= '0;
      r_holdCnt   <= '0;
      // Pointer at the last requester so requester 0 is searched first
      r_lastGrant <= IDXW'(NREQ - 1);
    end else begin
      r_ack     <= w_ackNext;
      r_writeEn <= w_winValid;
      r_holdCnt <= w_holdCntNext;
      if (w_winValid) begin
        r_data      <= w_dataNext;
        r_grantId   <= w_winIdx;
        r_lastGrant <= w_winIdx;
        r_count     <= r_count + 1'b1;
      end
    end
  end

  assign bus.ack              = r_ack;
  assign bus.reg_write_enable = r_writeEn;
  assign bus.reg_data_write   = r_data;
  assign bus.grant_id         = r_grantId;
  assign bus.busy             = (r_state == GRANT);
  assign bus.write_count      = r_count;

endmodule : reg_write_arbiter
`default_nettype wire

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of the shared register.
REQ-002 Parameter NREQ, default 4: number of requesters (2..8).
REQ-003 Parameter MAX_HOLD, default 4: maximum consecutive grants to one requester while it asserts hold.
REQ-004 Port clk, input, 1: single clock; all arbiter state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port req, input, NREQ: per-requester write request.
REQ-007 Port hold, input, NREQ: per-requester request to keep its grant for the next write.
REQ-008 Port wdata, input, NREQ*WIDTH: requester data; slice i is bits [i*WIDTH +: WIDTH].
REQ-009 Port ack, output, NREQ: one-hot, one-cycle pulse marking the requester whose write is issued.
REQ-010 Port reg_write_enable, output, 1: write enable to the shared falling-edge register.
REQ-011 Port reg_data_write, output, WIDTH: data to the shared register.
REQ-012 Port grant_id, output, clog2(NREQ): index of the current or last winner.
REQ-013 Port busy, output, 1: high while the FSM is in GRANT.
REQ-014 Port write_count, output, 16: count of issued writes.

Function
REQ-015 The FSM SHALL have two states, IDLE and GRANT; all outputs are registered.
REQ-016 IDLE -> GRANT on a rising edge with req != 0; GRANT -> IDLE on a rising edge with req == 0; GRANT -> GRANT otherwise, re-arbitrating every edge.
REQ-017 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NREQ; the first asserted req wins.
REQ-018 Hold exception: if the previous winner has req and hold both high and hold_cnt < MAX_HOLD-1, it SHALL win again and hold_cnt increments; otherwise round-robin applies and hold_cnt clears.
REQ-019 On the edge that selects a winner w, the block SHALL register ack = one-hot(w), reg_write_enable = 1, reg_data_write = wdata slice w, grant_id = w, last_grant = w.
REQ-020 On an edge with no winner, ack = 0 and reg_write_enable = 0; reg_data_write and grant_id keep their values.
REQ-021 Latency: request-to-ack is 1 cycle with no contention; the shared register captures the data on the falling edge inside the ack cycle.
REQ-022 Handshake: one ack means exactly one write; a requester SHALL deassert req in its ack cycle unless it wants another write; a req still high at the next edge is a new request.
REQ-023 wdata slice i SHALL be stable while req[i] is high; the block samples it only on the grant edge.
REQ-024 write_count SHALL increment by 1 on every edge that asserts reg_write_enable and SHALL wrap from 0xFFFF to 0.
REQ-025 Fairness: a continuously requesting requester SHALL be acked within (NREQ-1)*MAX_HOLD+1 cycles.
REQ-026 hold without req SHALL be ignored, and hold is evaluated only for the previous winner.

Reset
REQ-027 With reset low at a rising edge: state = IDLE; ack, reg_write_enable, reg_data_write, grant_id, busy, write_count and hold_cnt = 0; last_grant = NREQ-1, so requester 0 has first priority.
REQ-028 Reset low mid-GRANT SHALL drop reg_write_enable at that edge and discard all pending requests. A write enable already presented before that edge completes at the preceding falling edge.

Structure
REQ-029 The package reg_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the default parameter constants.
REQ-030 The rotating priority search SHALL live in one combinational sub-module, rr_pick (inputs: req, last_grant; outputs: valid, index).

Verification
REQ-031 Single request: req = 4'b0100, wdata[2] = 0xDEADBEEF after reset -> the next cycle has ack = 4'b0100, reg_write_enable = 1, reg_data_write = 0xDEADBEEF, grant_id = 2, write_count = 1.
REQ-032 Full contention: req = 4'b1111 held, no hold -> grant_id sequence 0,1,2,3,0; reg_write_enable high every cycle; busy high throughout.
REQ-033 Hold limit: req = 4'b0011, hold[0] = 1 continuously -> grant_id sequence 0,0,0,0,1,0,0,0,0,1 (MAX_HOLD = 4).
REQ-034 Wrap: preload write_count to 0xFFFE by issuing writes, then 3 writes -> write_count sequence 0xFFFF, 0x0000, 0x0001.
REQ-035 Reset mid-burst: req = 4'b1111 then reset low for one edge -> all outputs 0 at that edge; after release with req = 4'b1111, the first grant_id is 0.
REQ-036 Idle return: a single ack to requester 1, then req = 0 -> busy drops on the following edge and grant_id stays 1.
